btn_conditioner: RTL and testbench
==================================

# btn_conditioner

Parametrised, multi-channel successor to the push-button debouncer. It synchronises N_CH asynchronous button inputs, debounces each over a DEPTH-sample window taken on the slow sampling strobe, and produces a registered debounced level plus single-cycle press and release pulses. Press pulses are optionally auto-repeated per channel while the button is held. It sits between the board button pins and the game-control logic (movement, fire, game reset).

## Interface
- N_CH, 4: number of button channels
- DEPTH, 3: consecutive equal samples required to change the debounced level; legal range ≥2
- REPEAT_MASK, 4'b0000: per-channel auto-repeat enable; bit i set enables channel i
- REPEAT_DELAY, 16: sampling ticks from debounced rise to the first repeat press; ≥1
- REPEAT_RATE, 4: sampling ticks between subsequent repeat presses; ≥1
- clk  input  1  system clock
- rst_n  input  1  synchronous reset, active-low
- clk_debouncer  input  1  sampling strobe, one clk cycle wide; "tick" below
- btn  input  N_CH  raw asynchronous button inputs, active-high
- level  output  N_CH  debounced button state
- press  output  N_CH  one-clk pulse on debounced rise and on each auto-repeat
- release  output  N_CH  one-clk pulse on debounced fall

## Operation
- Synchroniser: a 2-flop chain per channel, clocked every clk and not gated by the tick. The output is btn_s.
- Window: a DEPTH-bit shift register per channel. On a tick, btn_s enters at the MSB and the LSB is discarded. The register holds its value between ticks.
- Level rule, evaluated on the tick using the post-shift window {btn_s, win[DEPTH-1:1]}:
  - All ones: level becomes 1.
  - All zeros: level becomes 0.
  - Otherwise: level holds.
- press[i] is 1 for exactly the clk cycle after the tick edge on which level[i] rises. release[i] is 1 for exactly the clk cycle after the tick edge on which level[i] falls.
- press[i] and release[i] are never 1 in the same cycle.
- Repeat FSM per channel, active only when REPEAT_MASK[i]=1; otherwise it stays in IDLE.
  - IDLE: on rise, cnt←0 and the FSM goes to DELAY.
  - DELAY: on each tick with level staying 1, cnt increments. When cnt reaches REPEAT_DELAY-1 on a tick, the FSM pulses press, sets cnt←0 and goes to REPEAT.
  - REPEAT: on each tick with level staying 1, cnt increments. When cnt reaches REPEAT_RATE-1, the FSM pulses press and sets cnt←0.
  - DELAY or REPEAT: on the fall tick, the FSM goes to IDLE and sets cnt←0. No repeat press is issued on that tick.
- cnt width is $clog2(max(REPEAT_DELAY, REPEAT_RATE)). It never exceeds max-1, so it cannot wrap.
- Reset (rst_n=0 at a clk edge) clears synchronisers, windows, level, press, release, cnt and FSM state. This holds mid-press or mid-repeat. A button held through reset reads as a fresh press once DEPTH high samples have been taken.
- A tick in the same cycle as rst_n=0 is ignored.

## Timing
- Every output is registered. Reset value of level, press and release is 0.
- Input to window: 2 clk of synchroniser, then the next tick.
- Debounce latency: level changes at the edge of the DEPTH-th consecutive tick that samples the new value through the synchroniser.
- Press/release latency: the pulse is coincident with the level change (same edge) and lasts one clk.
- First repeat press comes REPEAT_DELAY ticks after the rise tick. Later repeat presses come every REPEAT_RATE ticks.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.

## Structure
- Package btn_pkg holds:
  - the repeat FSM state typedef (IDLE, DELAY, REPEAT)
  - the synchroniser length constant (2)
  - a function for the cnt-width calculation
- Sub-module btn_channel holds one channel: synchroniser, window, level, press/release logic and repeat FSM. It takes DEPTH, REPEAT_DELAY, REPEAT_RATE and a REPEAT_EN bit as parameters.
- btn_conditioner instantiates btn_channel N_CH times in a generate loop and wires REPEAT_MASK[i] to each instance.

## Test plan
Common configuration for all scenarios: N_CH=4, DEPTH=3, REPEAT_MASK=4'b0010, REPEAT_DELAY=4, REPEAT_RATE=2, tick every 10 clk.
- Clean press on ch0, held 8 ticks, then released:
  - level[0] rises at the 3rd sampled tick, with a 1-clk press[0] pulse in the same cycle.
  - level[0] falls at the 3rd low tick, with a 1-clk release[0] pulse.
  - No repeat pulses on ch0.
- Bounce on ch2, pattern 1,0,1,1,0,1,1,1 over 8 ticks:
  - level[2] rises only after the final 1,1,1 run.
  - Exactly one press[2] pulse.
- Ch1 held 12 ticks after rise:
  - press[1] pulses at the rise tick, then at +4, +6, +8, +10 and +12 ticks.
  - Release on a repeat-due tick yields release[1] only, with no press.
- Ch0 and ch3 pressed on the same tick: both press bits are 1 in the same cycle. Ch0 has no repeat.
- rst_n low for 1 clk while ch1 is in REPEAT:
  - All outputs are 0 the next cycle and the FSM is IDLE.
  - With btn[1] still high, a new press[1] appears 3 ticks later and the repeat timing restarts from the delay.
- 1-clk glitch on btn[0] that falls between ticks: no change on level, press or release.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and constants for the multi-channel button conditioner.
package btn_pkg;

  // Auto-repeat state machine, one instance per channel
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  // Number of flops in each input synchroniser chain
  localparam int SYNC_LEN = 2;

  // Repeat counter width: wide enough for max(delay, rate)-1, never below 1 bit
  function automatic int cnt_width(input int delay, input int rate);
    int m;
    m = (delay > rate) ? delay : rate;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchroniser, tick-sampled debounce window, registered
// level with press/release pulses, and an optional auto-repeat state machine.
// The release pulse output is named "released" because "release" is a
// reserved word in SystemVerilog.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEPTH        = 3,
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 4,
  parameter bit REPEAT_EN    = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn,
  output logic level,
  output logic press,
  output logic released
);

  localparam int CNT_W = cnt_width(REPEAT_DELAY, REPEAT_RATE);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  logic [SYNC_LEN-1:0] sync;
  logic                btn_s;
  logic [DEPTH-1:0]    win;
  logic [DEPTH-1:0]    win_next;
  logic                all_hi;
  logic                all_lo;
  logic                rise;
  logic                fall;
  logic                rpt_due;
  rpt_state_t          state;
  logic [CNT_W-1:0]    cnt;

  assign btn_s    = sync[SYNC_LEN-1];
  // Window as it will look after this tick's shift; the level decision uses it
  assign win_next = {btn_s, win[DEPTH-1:1]};
  assign all_hi   = &win_next;
  assign all_lo   = ~|win_next;
  assign rise     = tick & all_hi & ~level;
  assign fall     = tick & all_lo & level;

  // A repeat press is due on a tick where the counter hits its terminal value,
  // unless that same tick is the one that drops the level
  assign rpt_due = tick & ~fall &
                   (((state == DELAY)  && (cnt == DELAY_LAST)) ||
                    ((state == REPEAT) && (cnt == RATE_LAST)));

  // Two-flop synchroniser, clocked every cycle independent of the tick
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_LEN-2:0], btn};
    end
  end

  // Debounce window shifts in the synchronised sample only on a tick
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win <= '0;
    end else if (tick) begin
      win <= win_next;
    end
  end

  // Registered level and single-cycle press/release pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level    <= 1'b0;
      press    <= 1'b0;
      released <= 1'b0;
    end else begin
      press    <= rise | rpt_due;
      released <= fall;
      if (rise) begin
        level <= 1'b1;
      end else if (fall) begin
        level <= 1'b0;
      end
    end
  end

  // Auto-repeat state machine; stays in IDLE when repeat is disabled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (tick) begin
      case (state)
        IDLE: begin
          if (rise && REPEAT_EN) begin
            state <= DELAY;
            cnt   <= '0;
          end
        end
        DELAY: begin
          if (fall) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DELAY_LAST) begin
            state <= REPEAT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REPEAT: begin
          if (fall) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == RATE_LAST) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel push-button conditioner: one independent btn_channel per
// button, all sharing the clock, reset and sampling strobe.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int              N_CH         = 4,
  parameter int              DEPTH        = 3,
  parameter logic [N_CH-1:0] REPEAT_MASK  = '0,
  parameter int              REPEAT_DELAY = 16,
  parameter int              REPEAT_RATE  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clk_debouncer,
  input  logic [N_CH-1:0] btn,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] released
);

  for (genvar i = 0; i < N_CH; i++) begin : gen_ch
    btn_channel #(
      .DEPTH       (DEPTH),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE),
      .REPEAT_EN   (REPEAT_MASK[i])
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick    (clk_debouncer),
      .btn     (btn[i]),
      .level   (level[i]),
      .press   (press[i]),
      .released(released[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Randomised bench for btn_conditioner with a sample-count reference model.
module tb_btn_conditioner;

  localparam int         N_CH  = 4;
  localparam int         DEPTH = 3;
  localparam logic [3:0] MASK  = 4'b0010;
  localparam int         RD    = 4;
  localparam int         RR    = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            clk_debouncer;
  logic [N_CH-1:0] btn;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] press;
  logic [N_CH-1:0] released;

  btn_conditioner #(
    .N_CH(N_CH), .DEPTH(DEPTH), .REPEAT_MASK(MASK),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clk_debouncer(clk_debouncer),
    .btn(btn), .level(level), .press(press), .released(released)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;
  int npress [N_CH];

  // Reference model state: input delay line, sample run lengths, ticks since rise
  logic [N_CH-1:0] d1, d2, last, m_lvl, m_prs, m_rel;
  int              run [N_CH];
  int              k   [N_CH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_step(input logic [N_CH-1:0] b, input logic r, input logic t);
    logic [N_CH-1:0] samp;
    if (!r) begin
      d1 = '0; d2 = '0; last = '0; m_lvl = '0; m_prs = '0; m_rel = '0;
      for (int i = 0; i < N_CH; i++) begin
        run[i] = DEPTH;
        k[i]   = 0;
      end
    end else begin
      samp  = d2;
      d2    = d1;
      d1    = b;
      m_prs = '0;
      m_rel = '0;
      if (t) begin
        for (int i = 0; i < N_CH; i++) begin
          if (samp[i] == last[i]) begin
            if (run[i] < DEPTH) run[i]++;
          end else begin
            run[i] = 1;
          end
          last[i] = samp[i];
          if (run[i] >= DEPTH && samp[i] != m_lvl[i]) begin
            m_lvl[i] = samp[i];
            if (samp[i]) begin
              m_prs[i] = 1'b1;
              k[i]     = 0;
            end else begin
              m_rel[i] = 1'b1;
            end
          end else if (m_lvl[i] && MASK[i]) begin
            k[i]++;
            if (k[i] == RD || (k[i] > RD && (k[i] - RD) % RR == 0)) m_prs[i] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic cyc_step(input logic [N_CH-1:0] b, input logic r);
    btn           = b;
    rst_n         = r;
    clk_debouncer = (cyc % 10 == 9);
    @(posedge clk);
    model_step(b, r, clk_debouncer);
    @(negedge clk);
    chk("level",   32'(level),    32'(m_lvl));
    chk("press",   32'(press),    32'(m_prs));
    chk("release", 32'(released), 32'(m_rel));
    for (int i = 0; i < N_CH; i++) if (press[i]) npress[i]++;
    cyc++;
  endtask

  task automatic periods(input int n, input logic [N_CH-1:0] b);
    repeat (n * 10) cyc_step(b, 1'b1);
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < N_CH; i++) npress[i] = 0;
  endtask

  initial begin
    logic [N_CH-1:0] cur, b;
    logic            r;
    btn = '0; rst_n = 1'b0; clk_debouncer = 1'b0;
    clr_cnt();
    @(negedge clk);
    repeat (3) cyc_step('0, 1'b0);
    chk("rst_out", 32'({level, press, released}), 32'd0);
    cyc = 0;

    // Clean press on ch0, 8 ticks held, then released
    clr_cnt();
    periods(8, 4'b0001);
    periods(4, 4'b0000);
    chk("s1_press0", 32'(npress[0]), 32'd1);

    // Bounce on ch2
    clr_cnt();
    foreach (b[i]) b[i] = 1'b0;
    for (int j = 0; j < 8; j++) begin
      cur = 8'b1110_1101 >> j;
      periods(1, {1'b0, cur[0], 2'b00});
    end
    periods(4, 4'b0000);
    chk("s2_press2", 32'(npress[2]), 32'd1);

    // Ch1 auto-repeat: rise, repeats at +4..+12, release lands on a due tick
    clr_cnt();
    periods(14, 4'b0010);
    periods(4, 4'b0000);
    chk("s3_press1", 32'(npress[1]), 32'd6);

    // Ch0 and ch3 together
    clr_cnt();
    periods(3, 4'b1001);
    chk("s4_both", 32'(press), 32'h9);
    periods(6, 4'b1001);
    chk("s4_norpt0", 32'(npress[0]), 32'd1);
    chk("s4_norpt3", 32'(npress[3]), 32'd1);
    periods(4, 4'b0000);

    // Reset while ch1 is repeating, button kept high
    periods(9, 4'b0010);
    repeat (4) cyc_step(4'b0010, 1'b1);
    cyc_step(4'b0010, 1'b0);
    chk("s5_rst", 32'({level, press, released}), 32'd0);
    clr_cnt();
    repeat (5) cyc_step(4'b0010, 1'b1);
    periods(6, 4'b0010);
    chk("s5_restart", 32'(npress[1]), 32'd2);
    periods(4, 4'b0000);

    // One-cycle glitch between ticks
    clr_cnt();
    repeat (3) cyc_step(4'b0000, 1'b1);
    cyc_step(4'b0001, 1'b1);
    repeat (6) cyc_step(4'b0000, 1'b1);
    periods(3, 4'b0000);
    chk("s6_glitch", 32'(level), 32'd0);
    chk("s6_nopress", 32'(npress[0]), 32'd0);

    // Randomised traffic with glitches and occasional resets
    cur = '0;
    for (int p = 0; p < 200; p++) begin
      for (int i = 0; i < N_CH; i++) if ($urandom_range(2) == 0) cur[i] = ~cur[i];
      for (int c = 0; c < 10; c++) begin
        b = cur;
        if ($urandom_range(19) == 0) b[$urandom_range(N_CH - 1)] ^= 1'b1;
        r = ($urandom_range(149) != 0);
        cyc_step(b, r);
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
